// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversampled
// Brief    : 8N1-style UART receiver driven by an oversample tick enable.
// Revision : 1.0
// ============================================================================

module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameError,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] c_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [TW-1:0]          r_tick, w_tick_nxt;
    logic [BW-1:0]          r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0]   r_data, w_data_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_ferr, w_ferr_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_sync;

    // Synchronizer resets to all-ones so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        if (rxTick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_sync) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (r_tick == c_TICK_MID) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_shift_nxt = {w_rx_sync, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit + 1'b1;
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (w_rx_sync) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Held-low line must return high before a new start is armed.
                    if (w_rx_sync) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign rxData     = r_data;
    assign rxValid    = r_valid;
    assign frameError = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_oversampled
// Brief    : Scoreboard bench; frames issued tick-timed, pulses checked by monitor.
// Revision : 1.0
// ============================================================================

module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxTick;
    logic       rx;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameError;
    logic       busy;

    uart_rx_oversampled #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxTick    (rxTick),
        .rx        (rx),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .frameError(frameError),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clk while enabled; 16 ticks = 64 clk bit period.
    bit tick_en = 1'b0;
    int tick_phase = 0;
    always @(negedge clk) begin
        if (tick_en) begin
            tick_phase = (tick_phase + 1) % 4;
            rxTick = (tick_phase == 0);
        end else begin
            rxTick = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rxValid === 1'b1 || frameError === 1'b1) begin
            check("valid_ferr_exclusive", {30'd0, rxValid, frameError} == 32'd3, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=0x%0h expected none",
                         rxValid, frameError, rxData);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {31'd0, frameError}, {31'd0, e.is_err});
                check("rx_data", {24'd0, rxData}, {24'd0, e.data});
                if (rxValid === 1'b1) begin
                    check("busy_falls_with_valid", {30'd0, prev_busy, busy}, 32'd2);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (rxTick !== 1'b1);
        end
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    // Reference: a frame with a high stop bit delivers its byte; a low stop
    // bit yields a framing error with the last good byte still presented.
    task automatic send_frame(input logic [7:0] d, input bit stop_hi);
        exp_t e;
        if (stop_hi) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        sb.push_back(e);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(stop_hi, 16);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        reset   = 1'b1;
        rx      = 1'b1;
        rxTick  = 1'b0;
        tick_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rxData", {24'd0, rxData}, 32'd0);
        check("reset_rxValid", {31'd0, rxValid}, 32'd0);
        check("reset_frameError", {31'd0, frameError}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_ticks(4);

        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, 16);
        check("idle_after_A5", {31'd0, busy}, 32'd0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 16);

        send_frame(8'h3C, 1'b0);
        send_bit(1'b0, 48);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        check("break_data_kept", {24'd0, rxData}, 32'hFF);
        send_bit(1'b1, 2);
        check("break_released", {31'd0, busy}, 32'd0);
        send_bit(1'b1, 16);

        send_bit(1'b0, 3);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b1, 8);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        send_bit(1'b1, 16);

        d = 8'h5A;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        send_bit(d[4], 8);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        last_good = 8'h00;
        check("abort_rxData", {24'd0, rxData}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        send_bit(1'b1, 32);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, 16);

        d = 8'hC3;
        begin
            exp_t e;
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
            sb.push_back(e);
        end
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(d[i], 16);
        send_bit(d[3], 5);
        tick_en = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            rx = 1'($urandom_range(0, 1));
        end
        rx = d[3];
        check("freeze_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        tick_en = 1'b1;
        wait_ticks(11);
        for (int i = 4; i < 8; i++) send_bit(d[i], 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        check("freeze_result", {24'd0, rxData}, 32'hC3);

        for (int k = 0; k < 8; k++) begin
            int gap;
            d   = 8'($urandom);
            gap = $urandom_range(0, 20);
            send_frame(d, 1'b1);
            if (gap > 0) send_bit(1'b1, gap);
        end

        send_bit(1'b1, 32);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
